// File: rtl/posit_decode_pipe_if.sv
// Handshake and result bundle for the posit decode pipeline.
// The slave side is the decoder and the master side is its user.
interface posit_decode_pipe_if #(
    parameter int WIDTH = 8,
    parameter int EXP   = 2,
    parameter int LANES = 2
);
    localparam int REGI = $clog2(WIDTH) + 1;
    localparam int MTS  = WIDTH - 3 - EXP;
    localparam int SCL  = REGI + EXP;

    logic                    vld_i;
    logic                    rdy_o;
    logic [LANES*WIDTH-1:0]  data_i;
    logic                    vld_o;
    logic                    rdy_i;
    logic [2*LANES-1:0]      cls_o;
    logic [LANES-1:0]        sign_o;
    logic [LANES*REGI-1:0]   regi_o;
    logic [LANES*EXP-1:0]    exp_o;
    logic [LANES*MTS-1:0]    mts_o;
    logic [LANES*SCL-1:0]    scl_o;
    logic [15:0]             nar_cnt_o;

    modport slave (
        input  vld_i, data_i, rdy_i,
        output rdy_o, vld_o, cls_o, sign_o, regi_o,
        output exp_o, mts_o, scl_o, nar_cnt_o
    );

    modport master (
        output vld_i, data_i, rdy_i,
        input  rdy_o, vld_o, cls_o, sign_o, regi_o,
        input  exp_o, mts_o, scl_o, nar_cnt_o
    );
endinterface

// File: rtl/posit_decode_pipe.sv
// Two-stage multi-lane posit decoder: S1 classifies and takes magnitude,
// S2 splits the magnitude into regime, exponent and fraction fields.
module posit_decode_pipe #(
    parameter int WIDTH = 8,
    parameter int EXP   = 2,
    parameter int LANES = 2
) (
    input  logic clk_i,
    input  logic rstn,
    posit_decode_pipe_if.slave bus
);
    localparam int REGI = $clog2(WIDTH) + 1;
    localparam int MTS  = WIDTH - 3 - EXP;
    localparam int SCL  = REGI + EXP;
    localparam int MW   = WIDTH - 1;

    localparam logic [1:0] CLS_ZERO = 2'b00;
    localparam logic [1:0] CLS_NORM = 2'b01;
    localparam logic [1:0] CLS_NAR  = 2'b10;
    localparam logic [WIDTH-1:0] NAR_PAT = {1'b1, {MW{1'b0}}};

    logic s1_vld_q;
    logic s2_vld_q;
    logic s1_en;
    logic s2_en;
    logic in_fire;

    logic [LANES-1:0][1:0]    s1_cls_q, s1_cls_d;
    logic [LANES-1:0]         s1_sign_q, s1_sign_d;
    logic [LANES-1:0][MW-1:0] s1_mag_q, s1_mag_d;

    logic [LANES-1:0][1:0]      s2_cls_q, s2_cls_d;
    logic [LANES-1:0]           s2_sign_q, s2_sign_d;
    logic [LANES-1:0][REGI-1:0] s2_regi_q, s2_regi_d;
    logic [LANES-1:0][EXP-1:0]  s2_exp_q, s2_exp_d;
    logic [LANES-1:0][MTS-1:0]  s2_mts_q, s2_mts_d;
    logic [LANES-1:0][SCL-1:0]  s2_scl_q, s2_scl_d;

    logic [15:0] nar_cnt_q, nar_cnt_d;
    logic [16:0] nar_add;
    logic [16:0] nar_sum;

    // S2 drains when empty or consumed; S1 moves whenever S2 has room.
    assign s2_en   = !s2_vld_q || bus.rdy_i;
    assign s1_en   = !s1_vld_q || s2_en;
    assign in_fire = bus.vld_i && s1_en;

    always_comb begin
        logic [WIDTH-1:0] word;
        logic [WIDTH-1:0] neg;
        s1_cls_d  = '0;
        s1_sign_d = '0;
        s1_mag_d  = '0;
        nar_add   = '0;
        word      = '0;
        neg       = '0;
        for (int n = 0; n < LANES; n++) begin
            word = bus.data_i[n*WIDTH +: WIDTH];
            neg  = -word;
            if (word == '0) begin
                s1_cls_d[n] = CLS_ZERO;
            end else if (word == NAR_PAT) begin
                s1_cls_d[n] = CLS_NAR;
                nar_add     = nar_add + 17'd1;
            end else begin
                s1_cls_d[n] = CLS_NORM;
            end
            s1_sign_d[n] = word[WIDTH-1];
            s1_mag_d[n]  = word[WIDTH-1] ? neg[MW-1:0] : word[MW-1:0];
        end
    end

    assign nar_sum   = {1'b0, nar_cnt_q} + nar_add;
    assign nar_cnt_d = nar_sum[16] ? 16'hFFFF : nar_sum[15:0];

    always_comb begin
        logic                   first;
        logic                   stop;
        int                     r;
        logic [MW-1:0]          rest;
        logic signed [REGI-1:0] k;
        s2_cls_d  = '0;
        s2_sign_d = '0;
        s2_regi_d = '0;
        s2_exp_d  = '0;
        s2_mts_d  = '0;
        s2_scl_d  = '0;
        first     = 1'b0;
        stop      = 1'b0;
        r         = 0;
        rest      = '0;
        k         = '0;
        for (int n = 0; n < LANES; n++) begin
            first = s1_mag_q[n][MW-1];
            stop  = 1'b0;
            r     = 0;
            for (int i = MW - 1; i >= 0; i--) begin
                if (!stop) begin
                    if (s1_mag_q[n][i] == first) r = r + 1;
                    else stop = 1'b1;
                end
            end
            // Drop the run and its terminator; vacated LSBs fill with zeros.
            rest = s1_mag_q[n] << (r + 1);
            k    = first ? REGI'(r - 1) : REGI'(-r);
            s2_cls_d[n] = s1_cls_q[n];
            if (s1_cls_q[n] == CLS_NORM) begin
                s2_sign_d[n] = s1_sign_q[n];
                s2_regi_d[n] = k;
                s2_exp_d[n]  = rest[MW-1 -: EXP];
                s2_mts_d[n]  = rest[MW-1-EXP -: MTS];
                s2_scl_d[n]  = {k, rest[MW-1 -: EXP]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            s1_vld_q  <= 1'b0;
            s1_cls_q  <= '0;
            s1_sign_q <= '0;
            s1_mag_q  <= '0;
            nar_cnt_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_cls_q  <= '0;
            s2_sign_q <= '0;
            s2_regi_q <= '0;
            s2_exp_q  <= '0;
            s2_mts_q  <= '0;
            s2_scl_q  <= '0;
        end else begin
            if (s1_en) s1_vld_q <= bus.vld_i;
            if (in_fire) begin
                s1_cls_q  <= s1_cls_d;
                s1_sign_q <= s1_sign_d;
                s1_mag_q  <= s1_mag_d;
                nar_cnt_q <= nar_cnt_d;
            end
            if (s2_en) s2_vld_q <= s1_vld_q;
            if (s2_en && s1_vld_q) begin
                s2_cls_q  <= s2_cls_d;
                s2_sign_q <= s2_sign_d;
                s2_regi_q <= s2_regi_d;
                s2_exp_q  <= s2_exp_d;
                s2_mts_q  <= s2_mts_d;
                s2_scl_q  <= s2_scl_d;
            end
        end
    end

    assign bus.rdy_o     = s1_en;
    assign bus.vld_o     = s2_vld_q;
    assign bus.cls_o     = s2_cls_q;
    assign bus.sign_o    = s2_sign_q;
    assign bus.regi_o    = s2_regi_q;
    assign bus.exp_o     = s2_exp_q;
    assign bus.mts_o     = s2_mts_q;
    assign bus.scl_o     = s2_scl_q;
    assign bus.nar_cnt_o = nar_cnt_q;
endmodule

// File: tb/tb_posit_decode_pipe.sv
// Scoreboard bench for posit_decode_pipe: bit-queue posit reference model,
// random traffic with backpressure, reset flush and NaR counter saturation.
module tb_posit_decode_pipe;
    localparam int W  = 8;
    localparam int E  = 2;
    localparam int L  = 2;
    localparam int RG = 4;
    localparam int MT = 3;
    localparam int SC = 6;

    typedef struct packed {
        logic [2*L-1:0]  cls;
        logic [L-1:0]    sign;
        logic [L*RG-1:0] regi;
        logic [L*E-1:0]  ex;
        logic [L*MT-1:0] mts;
        logic [L*SC-1:0] scl;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    exp_t sb[$];
    exp_t mon_got;
    int   tests = 0;
    int   fails = 0;
    int   nar_total = 0;
    bit   rand_rdy = 1'b0;

    posit_decode_pipe_if #(.WIDTH(W), .EXP(E), .LANES(L)) bus ();

    posit_decode_pipe #(.WIDTH(W), .EXP(E), .LANES(L)) dut (
        .clk_i (clk),
        .rstn  (rstn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t set_lane(input exp_t e, input int n, input int cls,
                                      input int sg, input int k, input int ex,
                                      input int mt);
        exp_t o;
        o = e;
        o.cls[2*n +: 2]   = 2'(cls);
        o.sign[n]         = sg[0];
        o.regi[n*RG +: RG] = RG'(k);
        o.ex[n*E +: E]    = E'(ex);
        o.mts[n*MT +: MT] = MT'(mt);
        o.scl[n*SC +: SC] = SC'(k * (1 << E) + ex);
        return o;
    endfunction

    // Reads the magnitude as a stream of bits and consumes fields in order.
    function automatic exp_t model(input logic [L*W-1:0] d);
        exp_t e;
        int   w, s, m, r, k, ex, mt;
        bit   first;
        bit   q[$];
        e = '0;
        for (int n = 0; n < L; n++) begin
            w = int'(d[n*W +: W]);
            if (w == 0) begin
                e = set_lane(e, n, 0, 0, 0, 0, 0);
            end else if (w == (1 << (W - 1))) begin
                e = set_lane(e, n, 2, 0, 0, 0, 0);
            end else begin
                s = (w >= (1 << (W - 1))) ? 1 : 0;
                m = s ? ((1 << W) - w) : w;
                m = m % (1 << (W - 1));
                q.delete();
                for (int b = W - 2; b >= 0; b--) q.push_back(bit'((m >> b) & 1));
                first = q[0];
                r = 0;
                while (q.size() > 0 && q[0] == first) begin
                    void'(q.pop_front());
                    r++;
                end
                if (q.size() > 0) void'(q.pop_front());
                ex = 0;
                repeat (E) ex = ex * 2 + ((q.size() > 0) ? int'(q.pop_front()) : 0);
                mt = 0;
                repeat (MT) mt = mt * 2 + ((q.size() > 0) ? int'(q.pop_front()) : 0);
                k = first ? r - 1 : -r;
                e = set_lane(e, n, 1, s, k, ex, mt);
            end
        end
        return e;
    endfunction

    function automatic int nar_lanes(input logic [L*W-1:0] d);
        int c;
        c = 0;
        for (int n = 0; n < L; n++)
            if (d[n*W +: W] == {1'b1, {(W-1){1'b0}}}) c++;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic push_send(input logic [L*W-1:0] d, input exp_t e);
        int budget;
        budget = 0;
        bus.data_i = d;
        bus.vld_i  = 1'b1;
        while (!bus.rdy_o && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.rdy_o) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: rdy_o %b required 1", bus.rdy_o);
        end else begin
            sb.push_back(e);
            nar_total += nar_lanes(d);
        end
        @(negedge clk);
        bus.vld_i = 1'b0;
    endtask

    task automatic send(input logic [L*W-1:0] d);
        push_send(d, model(d));
    endtask

    task automatic set_rdy(input logic v);
        @(posedge clk);
        #1 bus.rdy_i = v;
        @(negedge clk);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sb.size() != 0 && b < 500) begin
            @(negedge clk);
            b++;
        end
        check("drain_left", 32'(sb.size()), 0);
    endtask

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 8'h80;
            default: return W'($urandom);
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (rand_rdy) bus.rdy_i = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (rstn && bus.vld_o) begin
            mon_got = {bus.cls_o, bus.sign_o, bus.regi_o,
                       bus.exp_o, bus.mts_o, bus.scl_o};
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out: got %h with empty scoreboard", mon_got);
            end else begin
                if (mon_got !== sb[0]) begin
                    fails++;
                    $display("FAIL out_fields: got %h required %h", mon_got, sb[0]);
                end
                if (bus.rdy_i) void'(sb.pop_front());
            end
        end
    end

    initial begin
        exp_t e;
        logic [L*W-1:0] d;
        bus.vld_i  = 1'b0;
        bus.data_i = '0;
        bus.rdy_i  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_vld_o", 32'(bus.vld_o), 0);
        check("rst_nar", 32'(bus.nar_cnt_o), 0);
        @(posedge clk);
        #3 rstn = 1'b1;
        @(negedge clk);
        check("rst_rdy_o", 32'(bus.rdy_o), 1);

        e = set_lane('0, 0, 1, 0, 0, 0, 0);
        e = set_lane(e, 1, 1, 0, 0, 2, 0);
        push_send(16'h5040, e);
        e = set_lane('0, 0, 1, 0, 6, 0, 0);
        e = set_lane(e, 1, 1, 0, -6, 0, 0);
        push_send(16'h017F, e);
        e = set_lane('0, 0, 1, 1, 0, 0, 0);
        e = set_lane(e, 1, 2, 0, 0, 0, 0);
        push_send(16'h80C0, e);
        drain();
        check("nar_one", 32'(bus.nar_cnt_o), 1);
        push_send(16'h0000, '0);
        drain();
        check("nar_zero_lanes", 32'(bus.nar_cnt_o), 1);

        set_rdy(1'b0);
        send({rnd_word(), rnd_word()});
        send({rnd_word(), rnd_word()});
        check("full_rdy_o", 32'(bus.rdy_o), 0);
        fork
            begin
                repeat (3) @(posedge clk);
                #1 bus.rdy_i = 1'b1;
            end
            begin
                send({rnd_word(), rnd_word()});
                send({rnd_word(), rnd_word()});
            end
        join
        drain();

        rand_rdy = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 4) == 0) @(negedge clk);
            send({rnd_word(), rnd_word()});
        end
        rand_rdy = 1'b0;
        set_rdy(1'b1);
        drain();
        check("nar_random", 32'(bus.nar_cnt_o), 32'(nar_total));

        set_rdy(1'b0);
        send(16'h8080);
        send({rnd_word(), rnd_word()});
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("midrst_vld_o", 32'(bus.vld_o), 0);
        check("midrst_nar", 32'(bus.nar_cnt_o), 0);
        sb.delete();
        nar_total = 0;
        @(posedge clk);
        #3 rstn = 1'b1;
        @(negedge clk);
        check("rel_rdy_o", 32'(bus.rdy_o), 1);
        set_rdy(1'b1);
        repeat (3) begin
            @(negedge clk);
            check("rel_no_stale", 32'(bus.vld_o), 0);
        end

        d = 16'h8080;
        while (nar_total < 65540) send(d);
        drain();
        check("nar_sat", 32'(bus.nar_cnt_o), 32'hFFFF);
        send(d);
        drain();
        check("nar_sat_hold", 32'(bus.nar_cnt_o), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
